// File: rtl/cla_nibble_seq_adder_pkg.sv
// -----------------------------------------------------------------------------
// cla_nibble_seq_adder_pkg
//   Shared definitions for the nibble-serial carry-look-ahead adder:
//     - state_t    : controller states (IDLE, RUN, DONE)
//     - NIBW       : width of one datapath slice in bits
//     - width_ok() : legality test for the WIDTH parameter
// -----------------------------------------------------------------------------
package cla_nibble_seq_adder_pkg;

    localparam int NIBW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // WIDTH must be a positive whole number of nibbles.
    function automatic bit width_ok(input int w);
        return (w >= NIBW) && ((w % NIBW) == 0);
    endfunction

endpackage

// File: rtl/cla_nibble_seq_adder_cla.sv
// -----------------------------------------------------------------------------
// carry_look_ahead
//   4-bit carry-look-ahead adder, purely combinational.
//   Ports:
//     A, B  in  [3:0]  addends
//     Cin   in         carry-in
//     sum   out [3:0]  A + B + Cin (low 4 bits)
//     Cout  out        carry-out of bit 3
// -----------------------------------------------------------------------------
module carry_look_ahead (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       Cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is expanded directly from Cin, no ripple between bits.
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign sum  = w_p ^ w_c[3:0];
    assign Cout = w_c[4];

endmodule

// File: rtl/cla_nibble_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_nibble_seq_adder
//   Multi-cycle WIDTH-bit adder. One 4-bit CLA slice is time-shared across the
//   operand, one nibble per cycle, LSB nibble first, with the carry registered
//   between nibbles. Valid/ready handshake on input and output.
//   {cout, sum} = a + b + cin, result presented NIB cycles after acceptance.
//   Ports:
//     clk        in            rising-edge clock
//     rst        in            synchronous active-high reset
//     in_valid   in            operands presented
//     in_ready   out           block can accept operands (IDLE)
//     a, b       in  [WIDTH]   operands
//     cin        in            carry-in to nibble 0
//     out_valid  out           result available (DONE)
//     out_ready  in            consumer accepts result
//     sum        out [WIDTH]   registered sum, valid only with out_valid
//     cout       out           registered carry-out of the top nibble
//     busy       out           high in RUN or DONE
// -----------------------------------------------------------------------------
module cla_nibble_seq_adder
    import cla_nibble_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB  = WIDTH / NIBW;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    if (!width_ok(WIDTH)) begin : g_width_bad
        $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic [NIBW-1:0]   w_nib_a;
    logic [NIBW-1:0]   w_nib_b;
    logic [NIBW-1:0]   w_slice_sum;
    logic              w_slice_cout;
    logic              w_accept;
    logic              w_last;

    // Operand nibble selected by the running index.
    assign w_nib_a = r_a[int'(r_idx) * NIBW +: NIBW];
    assign w_nib_b = r_b[int'(r_idx) * NIBW +: NIBW];

    carry_look_ahead u_slice (
        .A    (w_nib_a),
        .B    (w_nib_b),
        .Cin  (r_carry),
        .sum  (w_slice_sum),
        .Cout (w_slice_cout)
    );

    assign w_last = (r_idx == LAST_IDX);

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Release goes to IDLE only; the next accept is a cycle later.
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[int'(r_idx) * NIBW +: NIBW] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_nibble_seq_adder
//   Directed and random-stream bench for cla_nibble_seq_adder (WIDTH=16).
// -----------------------------------------------------------------------------
module tb_cla_nibble_seq_adder;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;

    int unsigned   checks   = 0;
    int unsigned   failures = 0;

    cla_nibble_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, optional disturbance during RUN, optional
    // out_ready stall in DONE, then handshake and return to IDLE.
    task automatic run_txn(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                           input logic cin_i, input int stall, input bit disturb,
                           input logic [W-1:0] exp_sum, input logic exp_cout);
        int n;
        check("pre_in_ready", 32'(in_ready), 32'd1);
        a = a_i; b = b_i; cin = cin_i; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_in_ready", 32'(in_ready), 32'd0);
            if (disturb && n == 0) begin
                a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            n++;
            if (out_valid) break;
        end
        check("latency", 32'(n), 32'd4);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'(exp_sum));
            check("stall_cout", 32'(cout), 32'(exp_cout));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("sum", 32'(sum), 32'(exp_sum));
        check("cout", 32'(cout), 32'(exp_cout));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W:0]  exp_v;
        logic [W:0]  q[$];
        int unsigned cyc;
        int unsigned last_acc;
        int unsigned retired;
        bit          first;
        bit          acc;
        bit          hs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        run_txn(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 16'h5555, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0000, 1'b1);
        run_txn(16'h0000, 16'hFFFF, 1'b1, 0, 1'b0, 16'h0000, 1'b1);
        run_txn(16'h8000, 16'h8000, 1'b1, 6, 1'b0, 16'h0001, 1'b1);
        run_txn(16'h00F0, 16'h0010, 1'b0, 0, 1'b1, 16'h0100, 1'b0);
        // The disturbance pulse must not have started another transaction.
        for (int i = 0; i < 6; i++) begin
            check("no_second_txn", 32'(busy), 32'd0);
            tick();
        end

        // Reset in the second RUN cycle discards the partial result.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mid_rst_no_pulse", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // Random back-to-back stream with random consumer stalls.
        cyc = 0; last_acc = 0; retired = 0; first = 1'b1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        while (retired < 1000 && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_v = q.pop_front();
                    check("rnd_result", 32'({cout, sum}), 32'(exp_v));
                    retired++;
                end
            end
            if (acc) begin
                q.push_back(17'(a) + 17'(b) + 17'(cin));
                if (!first) check("rnd_interval", cyc - last_acc, (cyc - last_acc >= 5) ? cyc - last_acc : 32'd5);
                last_acc = cyc;
                first = 1'b0;
            end
            tick();
            cyc++;
            if (acc) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rnd_retired", retired, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
